// File: rtl/ram8_arbiter_if.sv
// ram8_arbiter_if: bundle of the two requester handshakes, the RAM8 port
// and the busy flag.
//   slave  : seen by the arbiter (requests and ram_dout in; acks, read data,
//            RAM controls and busy out)
//   master : seen by requesters and the RAM model (the mirror image)
interface ram8_arbiter_if #(
   parameter int DW = 16,
   parameter int AW = 3
);
   logic          req0, we0, ack0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] din0, rdata0;
   logic          req1, we1, ack1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] din1, rdata1;
   logic          ram_e, ram_w, ram_r;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din, ram_dout;
   logic          busy;

   modport slave (
      input  req0, we0, addr0, din0, req1, we1, addr1, din1, ram_dout,
      output ack0, rdata0, ack1, rdata1,
             ram_e, ram_w, ram_r, ram_addr, ram_din, busy
   );

   modport master (
      output req0, we0, addr0, din0, req1, we1, addr1, din1, ram_dout,
      input  ack0, rdata0, ack1, rdata1,
             ram_e, ram_w, ram_r, ram_addr, ram_din, busy
   );
endinterface

// File: rtl/ram8_arbiter.sv
// ram8_arbiter: two-port round-robin arbiter/sequencer for the RAM8 block.
// Each transaction takes three edges: IDLE (grant and drive the RAM port),
// ACCESS (RAM executes; controls drop), RESP (capture read data, pulse ack).
// Ports:
//   clk, rst  - rising-edge clock, asynchronous active-high reset
//   bus       - ram8_arbiter_if.slave: req/we/addr/din in and ack/rdata out
//               per requester, ram_e/w/r/addr/din out, ram_dout in, busy out
// Optional (macro RAM8ARB_STATS_EN):
//   cnt0, cnt1 - 8-bit saturating ack counters per requester
// Every output is registered.
module ram8_arbiter #(
   parameter int DW = 16,
   parameter int AW = 3
) (
   input logic clk,
   input logic rst,
   ram8_arbiter_if.slave bus
`ifdef RAM8ARB_STATS_EN
   ,
   output logic [7:0] cnt0,
   output logic [7:0] cnt1
`endif
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t        state, nstate;
   logic          ptr, sel, wr;              // rr pointer, current winner, winner's we
   logic          ptr_d, sel_d, wr_d;
   logic          e_d, w_d, r_d, ack0_d, ack1_d, busy_d;
   logic [AW-1:0] addr_d;
   logic [DW-1:0] din_d, rd0_d, rd1_d;
   logic          gnt1;

   // requester 1 wins when it is alone or when both ask and the pointer says so
   assign gnt1 = bus.req1 & (~bus.req0 | ptr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (bus.req0 | bus.req1) nstate = ACCESS;
         ACCESS:  nstate = RESP;
         RESP:    nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_comb begin
      e_d    = 1'b0;
      w_d    = 1'b0;
      r_d    = 1'b0;
      ack0_d = 1'b0;
      ack1_d = 1'b0;
      addr_d = bus.ram_addr;
      din_d  = bus.ram_din;
      rd0_d  = bus.rdata0;
      rd1_d  = bus.rdata1;
      ptr_d  = ptr;
      sel_d  = sel;
      wr_d   = wr;
      busy_d = (nstate != IDLE);
      case (state)
         IDLE: begin
            if (bus.req0 | bus.req1) begin
               sel_d  = gnt1;
               wr_d   = gnt1 ? bus.we1   : bus.we0;
               addr_d = gnt1 ? bus.addr1 : bus.addr0;
               din_d  = gnt1 ? bus.din1  : bus.din0;
               e_d    = 1'b1;
               w_d    = wr_d;
               r_d    = ~wr_d;
            end
         end
         RESP: begin
            // DOut was refreshed on the ACCESS edge, so it is valid here
            if (!wr) begin
               if (sel) rd1_d = bus.ram_dout;
               else     rd0_d = bus.ram_dout;
            end
            ack0_d = ~sel;
            ack1_d = sel;
            ptr_d  = ~sel;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.ram_e    <= 1'b0;
         bus.ram_w    <= 1'b0;
         bus.ram_r    <= 1'b0;
         bus.ram_addr <= '0;
         bus.ram_din  <= '0;
         bus.ack0     <= 1'b0;
         bus.ack1     <= 1'b0;
         bus.rdata0   <= '0;
         bus.rdata1   <= '0;
         bus.busy     <= 1'b0;
         ptr          <= 1'b0;
         sel          <= 1'b0;
         wr           <= 1'b0;
      end else begin
         bus.ram_e    <= e_d;
         bus.ram_w    <= w_d;
         bus.ram_r    <= r_d;
         bus.ram_addr <= addr_d;
         bus.ram_din  <= din_d;
         bus.ack0     <= ack0_d;
         bus.ack1     <= ack1_d;
         bus.rdata0   <= rd0_d;
         bus.rdata1   <= rd1_d;
         bus.busy     <= busy_d;
         ptr          <= ptr_d;
         sel          <= sel_d;
         wr           <= wr_d;
      end
   end

`ifdef RAM8ARB_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (bus.ack0 && cnt0 != 8'hFF) cnt0 <= cnt0 + 8'd1;
         if (bus.ack1 && cnt1 != 8'hFF) cnt1 <= cnt1 + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ram8_arbiter.sv
// tb_ram8_arbiter: randomized and directed bench for ram8_arbiter with a
// behavioural RAM8 and a transaction-level reference (memory array, grant
// order predicted from round-robin fairness).
module tb_ram8_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ram8_arbiter_if #(.DW(16), .AW(3)) bus ();

`ifdef RAM8ARB_STATS_EN
   logic [7:0] cnt0, cnt1;
   ram8_arbiter #(.DW(16), .AW(3)) dut (.clk(clk), .rst(rst), .bus(bus), .cnt0(cnt0), .cnt1(cnt1));
`else
   ram8_arbiter #(.DW(16), .AW(3)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   // behavioural RAM8
   logic [15:0] ram [8] = '{default: 16'h0};
   initial bus.ram_dout = 16'h0;
   always @(posedge clk) begin
      if (bus.ram_e && bus.ram_w)      ram[bus.ram_addr] <= bus.ram_din;
      else if (bus.ram_e && bus.ram_r) bus.ram_dout      <= ram[bus.ram_addr];
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // continuous protocol invariants and a snapshot of the last RAM command
   logic        prev_e = 1'b0;
   logic        snap_w = 1'b0, snap_r = 1'b0;
   logic [2:0]  snap_addr = '0;
   logic [15:0] snap_din = '0;
   always @(negedge clk) begin
      if (!rst) begin
         chk("w_and_r", 32'(bus.ram_w & bus.ram_r), 32'd0);
         chk("e_outside_busy", 32'(bus.ram_e & ~bus.busy), 32'd0);
         chk("e_one_cycle", 32'(bus.ram_e & prev_e), 32'd0);
         chk("ack_both", 32'(bus.ack0 & bus.ack1), 32'd0);
      end
      prev_e <= bus.ram_e;
      if (bus.ram_e) begin
         snap_w    <= bus.ram_w;
         snap_r    <= bus.ram_r;
         snap_addr <= bus.ram_addr;
         snap_din  <= bus.ram_din;
      end
   end

   // reference model
   typedef struct { bit we; logic [2:0] addr; logic [15:0] din; } txn_t;
   txn_t        q0[$], q1[$];
   txn_t        cur0, cur1;
   bit          act0, act1;
   logic [15:0] mdl_mem [8] = '{default: 16'h0};
   logic [15:0] exp_rd0 = '0, exp_rd1 = '0;
   bit          last_win = 1'b1;   // pointer 0 means port 0 wins next tie
   int          lat0, lat1;
   int          nack0 = 0, nack1 = 0;

   task automatic drive0();
      if (!act0 && q0.size() > 0) begin
         cur0 = q0.pop_front(); act0 = 1'b1; lat0 = 0;
         bus.req0 = 1'b1; bus.we0 = cur0.we; bus.addr0 = cur0.addr; bus.din0 = cur0.din;
      end else if (!act0) bus.req0 = 1'b0;
   endtask

   task automatic drive1();
      if (!act1 && q1.size() > 0) begin
         cur1 = q1.pop_front(); act1 = 1'b1; lat1 = 0;
         bus.req1 = 1'b1; bus.we1 = cur1.we; bus.addr1 = cur1.addr; bus.din1 = cur1.din;
      end else if (!act1) bus.req1 = 1'b0;
   endtask

   task automatic apply(input txn_t t, inout logic [15:0] rd);
      if (t.we) mdl_mem[t.addr] = t.din;
      else      rd = mdl_mem[t.addr];
   endtask

   // run both queues to completion; called at a negedge with the DUT idle
   task automatic run_all();
      int pred[$];
      int got[$];
      int n0 = q0.size();
      int n1 = q1.size();
      bit l = last_win;
      int guard = 0;
      int budget = 20 + 4 * (n0 + n1);
      while (n0 > 0 && n1 > 0) begin
         l = ~l; pred.push_back(int'(l));
         if (l) n1--; else n0--;
      end
      while (n0 > 0) begin pred.push_back(0); n0--; l = 1'b0; end
      while (n1 > 0) begin pred.push_back(1); n1--; l = 1'b1; end
      drive0(); drive1();
      while ((act0 || act1) && guard < budget) begin
         @(negedge clk);
         guard++; lat0++; lat1++;
         if (bus.ack0) begin
            chk("ack0_expected", 32'(act0), 32'd1);
            apply(cur0, exp_rd0); got.push_back(0); act0 = 1'b0; nack0++;
         end
         if (bus.ack1) begin
            chk("ack1_expected", 32'(act1), 32'd1);
            apply(cur1, exp_rd1); got.push_back(1); act1 = 1'b0; nack1++;
         end
         chk("rdata0", 32'(bus.rdata0), 32'(exp_rd0));
         chk("rdata1", 32'(bus.rdata1), 32'(exp_rd1));
`ifdef RAM8ARB_STATS_EN
         chk("cnt0", 32'(cnt0), 32'((nack0 > 255) ? 255 : nack0));
         chk("cnt1", 32'(cnt1), 32'((nack1 > 255) ? 255 : nack1));
`endif
         drive0(); drive1();
      end
      if (act0 || act1) begin
         chk("timeout", 32'd0, 32'd1);
         act0 = 1'b0; act1 = 1'b0; q0.delete(); q1.delete();
         bus.req0 = 1'b0; bus.req1 = 1'b0;
      end
      chk("ack_count", 32'(got.size()), 32'(pred.size()));
      foreach (got[i]) if (i < pred.size()) chk("grant_order", 32'(got[i]), 32'(pred[i]));
      last_win = l;
   endtask

   task automatic push(input bit port, input bit we, input int a, input int d);
      txn_t t;
      t.we = we; t.addr = 3'(a); t.din = 16'(d);
      if (port) q1.push_back(t); else q0.push_back(t);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_e"},    32'(bus.ram_e), 32'd0);
      chk({tag, "_w"},    32'(bus.ram_w), 32'd0);
      chk({tag, "_r"},    32'(bus.ram_r), 32'd0);
      chk({tag, "_addr"}, 32'(bus.ram_addr), 32'd0);
      chk({tag, "_din"},  32'(bus.ram_din), 32'd0);
      chk({tag, "_ack"},  32'({bus.ack0, bus.ack1}), 32'd0);
      chk({tag, "_rd0"},  32'(bus.rdata0), 32'd0);
      chk({tag, "_rd1"},  32'(bus.rdata1), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.din0 = '0;
      bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.din1 = '0;
      act0 = 0; act1 = 0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // single write, latency and RAM command shape, then read back
      push(0, 1, 3, 16'h00AB);
      run_all();
      chk("wr_latency", 32'(lat0), 32'd3);
      chk("snap_w", 32'(snap_w), 32'd1);
      chk("snap_r", 32'(snap_r), 32'd0);
      chk("snap_addr", 32'(snap_addr), 32'd3);
      chk("snap_din", 32'(snap_din), 32'h00AB);
      push(0, 0, 3, 0);
      run_all();
      chk("rd_latency", 32'(lat0), 32'd3);
      chk("rd_ab", 32'(bus.rdata0), 32'h00AB);

      // port 1 fills memory, port 0 reads it back
      for (int i = 0; i < 8; i++) push(1, 1, i, i + 1);
      run_all();
      for (int i = 0; i < 8; i++) push(0, 0, i, 0);
      run_all();
      chk("rd_last", 32'(bus.rdata0), 32'd8);

      // both held: strict alternation
      for (int i = 0; i < 3; i++) begin
         push(0, 1, i, 16'h100 + i);
         push(1, 0, i, 0);
      end
      run_all();

      // reset during ACCESS of a write to addr 5 (holds 6)
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 3'd5; bus.din0 = 16'hFFFF;
      @(negedge clk);
      chk("pre_rst_e", 32'(bus.ram_e), 32'd1);
      bus.req0 = 0;
      rst = 1'b1;
      #1;
      chk_all_zero("midrst");
      @(negedge clk);
      rst = 1'b0;
      exp_rd0 = '0; exp_rd1 = '0; last_win = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("no_ack_after_rst", 32'({bus.ack0, bus.ack1}), 32'd0);
      end
      nack0 = 0; nack1 = 0;
      push(0, 0, 5, 0);
      push(1, 0, 5, 0);
      run_all();
      chk("aborted_wr_rd0", 32'(bus.rdata0), 32'd6);
      chk("aborted_wr_rd1", 32'(bus.rdata1), 32'd6);

      // randomized rounds
      for (int r = 0; r < 15; r++) begin
         int k0 = $urandom_range(0, 5);
         int k1 = $urandom_range(0, 5);
         for (int i = 0; i < k0; i++)
            push(0, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 16'hFFFF));
         for (int i = 0; i < k1; i++)
            push(1, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 16'hFFFF));
         run_all();
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

`ifdef RAM8ARB_STATS_EN
      for (int i = 0; i < 300; i++) begin
         push(0, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 16'hFFFF));
         if (i % 10 == 0) push(1, 0, $urandom_range(0, 7), 0);
      end
      run_all();
      chk("cnt0_sat", 32'(cnt0), 32'd255);
      chk("cnt1_exact", 32'(cnt1), 32'((nack1 > 255) ? 255 : nack1));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
